// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the binary-to-BCD display path
package calc_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam logic [3:0] BCD_ERR = 4'hE;
  function automatic int unsigned max_dec(input int digits);
    int unsigned r;
    r = 1;
    for (int k = 0; k < digits; k++) r = r * 10;
    return r - 1;
  endfunction
  localparam int unsigned MAX_DEC = max_dec(4);
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the digit is 5 or more
//   d : accumulator nibble in
//   q : corrected nibble out
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_comb q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 binary to packed BCD converter, one bit per clock
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, bin     : conversion request and value, taken only when idle
//   busy, done     : conversion in progress, one-cycle result strobe
//   bcd, ovf, neg  : packed digits (nibble 0 = ones), overflow, sign
//   SIGNED_INPUT_EN: define to treat bin as two's complement and drive neg
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf,
  output logic                neg
);
  localparam int AW = 4 * (DIGITS + 1);
  localparam int CW = $clog2(WIDTH + 1);
  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       acc_q, acc_d, adj;
  logic [WIDTH-1:0]    sh_q, sh_d, mag;
  logic                busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, ovf_w;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  for (genvar i = 0; i <= DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.d(acc_q[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  // the extra top digit is only nonzero when the value exceeds DIGITS decimal digits
  assign ovf_w = |acc_q[AW-1 -: 4];
`ifdef SIGNED_INPUT_EN
  logic sign_q, sign_d, neg_q, neg_d;
  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
  assign mag = bin[WIDTH-1] ? -bin : bin;
  assign neg = neg_q;
`else
  assign mag = bin;
  assign neg = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
`ifdef SIGNED_INPUT_EN
    sign_d  = sign_q;
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        cnt_d   = CW'(WIDTH);
        acc_d   = '0;
        sh_d    = mag;
        busy_d  = 1'b1;
`ifdef SIGNED_INPUT_EN
        sign_d  = bin[WIDTH-1];
`endif
      end
      SHIFT: begin
        {acc_d, sh_d} = {adj, sh_q} << 1;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        ovf_d   = ovf_w;
        bcd_d   = ovf_w ? {DIGITS{BCD_ERR}} : acc_q[4*DIGITS-1:0];
`ifdef SIGNED_INPUT_EN
        neg_d   = sign_q && |acc_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef SIGNED_INPUT_EN
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
`ifdef SIGNED_INPUT_EN
      sign_q  <= sign_d;
      neg_q   <= neg_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule
